iterative_arith_shift_divider: RTL and testbench
================================================

Name: iterative_arith_shift_divider

Overview:
- Sequential signed divide-by-power-of-2 unit: takes an N-bit signed operand and a runtime shift amount, then arithmetically right-shifts it one bit per clock.
- Valid/ready handshakes on both argument and result sides.
- Sits between a requester and a consumer that need variable-amount signed scaling with low area: one 1-bit shifter stage, no barrel shifter.

Parameters:
- N, 8, operand/result width in bits (N >= 2).
- SW (localparam), $clog2(N)+1, width of the shift-amount port; allows values >= N.

Ports:
- clk      input   1   clock
- rst_n    input   1   asynchronous, active-low reset
- arg_vld  input   1   argument valid
- arg_rdy  output  1   block can accept an argument
- a        input   N   signed dividend
- sh       input   SW  unsigned shift amount (divisor = 2**sh)
- res_vld  output  1   result valid
- res_rdy  input   1   consumer accepts result
- res      output  N   signed quotient

Behaviour:
- Reset (async, rst_n=0): state=IDLE, res_vld=0, data/counter/sticky registers=0, res=0. Applies immediately, including mid-SHIFT; any operation in flight is discarded.
- FSM states: IDLE, SHIFT, DONE.
- arg_rdy = (state==IDLE) || (state==DONE && res_rdy). Back-to-back operation is allowed: result handoff and new acceptance can happen in the same cycle.
- Accept = arg_vld && arg_rdy. On accept:
  - data <= a.
  - cnt <= min(sh, N-1); shifts of N or more clamp to N-1, which gives all sign bits.
  - sticky <= (sh >= N).
  - Next state is DONE if clamped cnt==0, else SHIFT.
- SHIFT, each cycle:
  - data <= {data[N-1], data[N-1:1]}.
  - sticky <= sticky | data[0].
  - cnt <= cnt-1.
  - If cnt==1, go to DONE.
- DONE:
  - res_vld=1.
  - res and res_vld are held stable while res_rdy=0.
  - On res_rdy=1: with arg_vld=1, accept the new argument (transition as above); otherwise go to IDLE.
- Latency: res_vld rises min(sh,N-1)+1 cycles after the accept cycle (sh=0: next cycle). Throughput is one result per min(sh,N-1)+1 cycles with res_rdy held high.
- arg_vld in SHIFT is ignored; arg_rdy=0, and the input need not stay stable.
- res_vld=0 in IDLE and SHIFT. res is don't-care there but must be X-free after reset.

Optional Feature:
- Macro: ITERATIVE_ARITH_SHIFT_DIVIDER_ROUND_TO_ZERO_EN.
- Defined: res = data + (data[N-1] && sticky). This gives C-style truncation toward zero (a / 2**sh). Example: -100 / 8 = -12. sh >= N with negative a gives 0.
- Undefined: res = data (floor, identical to >>>; -100 / 8 = -13). The sticky register and adder are removed.
- Latency and handshake are identical in both builds.

Decomposition:
- Package iterative_arith_shift_divider_pkg holds:
  - typedef enum logic [1:0] { IDLE, SHIFT, DONE } state_t.
  - Function clamp_shift(sh, N) returning min(sh, N-1).
- Sub-module arith_shift_right_by_one (parameter N): combinational 1-bit arithmetic shift built from concatenation only, plus shifted-out bit output lsb_out. Instantiated once inside the datapath.

Test Plan (N=8, res_rdy=1 unless stated):
- a=-100 (8'h9C), sh=3 -> res_vld 4 cycles after accept. Floor build: res=-13 (8'hF3). ROUND_TO_ZERO build: res=-12 (8'hF4).
- a=100, sh=3 -> res=12 in both builds. a=-128, sh=7 -> res=-1 in both builds. a=-128, sh=0 -> res=-128, res_vld on the cycle after accept.
- a=-128, sh=12 (clamped): floor -> -1, latency 8; ROUND_TO_ZERO -> 0. a=-1, sh=12: floor -1, ROUND_TO_ZERO 0.
- Backpressure: res_rdy=0 for 5 cycles in DONE -> res_vld and res stable, arg_rdy=0. Then res_rdy=1 with arg_vld=1 (a=64, sh=1) -> same-cycle handoff and accept; next result 32 after 2 cycles.
- Reset mid-operation: accept a=-100, sh=7; drive rst_n=0 two cycles later (async, between edges) -> res_vld=0 and arg_rdy=0 immediately. After release: IDLE, arg_rdy=1, and no stale res_vld.
- Randomized pairs (a, sh in 0..15) against a software golden model (floor, or truncation when the macro is defined) across 1000 operations, with random res_rdy/arg_vld gaps. All results must match.

Source files
------------

// File: rtl/iterative_arith_shift_divider_pkg.sv
// Shared types and helpers for the iterative arithmetic-shift divider.
package iterative_arith_shift_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Shift amounts of n or more all give the same result as n-1 (pure sign fill).
    function automatic int unsigned clamp_shift(input int unsigned sh, input int unsigned n);
        return (sh >= n) ? (n - 1) : sh;
    endfunction

endpackage

// File: rtl/iterative_arith_shift_divider_arith_shift_right_by_one.sv
// Single-bit arithmetic right shift built from wiring only; exposes the bit shifted out.
module arith_shift_right_by_one #(
    parameter int N = 8
) (
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic         lsb_out
);

    assign dout    = {din[N-1], din[N-1:1]};
    assign lsb_out = din[0];

endmodule

// File: rtl/iterative_arith_shift_divider.sv
// Sequential signed divide-by-2**sh: one arithmetic shift per clock.
// Optional macro ITERATIVE_ARITH_SHIFT_DIVIDER_ROUND_TO_ZERO_EN switches the result
// from floor (>>>) to truncation toward zero using a sticky bit and an adder.
module iterative_arith_shift_divider
    import iterative_arith_shift_divider_pkg::*;
#(
    parameter  int N  = 8,
    localparam int SW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          arg_vld,
    output logic          arg_rdy,
    input  logic [N-1:0]  a,
    input  logic [SW-1:0] sh,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [N-1:0]  res
);

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  data;
    logic [N-1:0]  data_shifted;
    logic          shift_lsb;
    logic [SW-1:0] cnt;
    logic [SW-1:0] cnt_init;
    logic          accept;

    assign cnt_init = SW'(clamp_shift(32'(sh), N));
    assign accept   = arg_vld && arg_rdy;

    arith_shift_right_by_one #(
        .N(N)
    ) u_shift (
        .din    (data),
        .dout   (data_shifted),
        .lsb_out(shift_lsb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept from IDLE or DONE, count down in SHIFT, drain DONE on res_rdy.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (cnt_init == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == SW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nxt = (cnt_init == '0) ? DONE : SHIFT;
                end else if (res_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; arg_rdy is held low while reset is asserted.
    always_comb begin
        arg_rdy = 1'b0;
        res_vld = 1'b0;
        case (state)
            IDLE:    arg_rdy = rst_n;
            DONE: begin
                res_vld = 1'b1;
                arg_rdy = rst_n && res_rdy;
            end
            default: begin
                arg_rdy = 1'b0;
                res_vld = 1'b0;
            end
        endcase
    end

`ifdef ITERATIVE_ARITH_SHIFT_DIVIDER_ROUND_TO_ZERO_EN
    logic sticky;

    // Datapath: load on accept, shift and collect discarded ones while in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data   <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else if (accept) begin
            data   <= a;
            cnt    <= cnt_init;
            sticky <= (sh >= SW'(N));
        end else if (state == SHIFT) begin
            data   <= data_shifted;
            cnt    <= cnt - SW'(1);
            sticky <= sticky | shift_lsb;
        end
    end

    // A negative quotient that lost any one bits is bumped up by one toward zero.
    assign res = data + N'(data[N-1] && sticky);
`else
    logic unused_shift_lsb;
    assign unused_shift_lsb = shift_lsb;

    // Datapath: load on accept, shift while in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            cnt  <= '0;
        end else if (accept) begin
            data <= a;
            cnt  <= cnt_init;
        end else if (state == SHIFT) begin
            data <= data_shifted;
            cnt  <= cnt - SW'(1);
        end
    end

    assign res = data;
`endif

endmodule

// File: tb/tb_iterative_arith_shift_divider.sv
// Self-checking bench for iterative_arith_shift_divider (N=8).
// Honors ITERATIVE_ARITH_SHIFT_DIVIDER_ROUND_TO_ZERO_EN for expected values.
module tb_iterative_arith_shift_divider;

    localparam int N  = 8;
    localparam int SW = 4;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          arg_vld = 1'b0;
    logic          res_rdy = 1'b1;
    logic [N-1:0]  a       = '0;
    logic [SW-1:0] sh      = '0;
    logic          arg_rdy;
    logic          res_vld;
    logic [N-1:0]  res;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_acc = 0;

    always #5 clk = ~clk;

    iterative_arith_shift_divider #(
        .N(N)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arg_vld(arg_vld),
        .arg_rdy(arg_rdy),
        .a      (a),
        .sh     (sh),
        .res_vld(res_vld),
        .res_rdy(res_rdy),
        .res    (res)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: no response within bound (cycle %0d)", name, cyc);
    endtask

    // Reference quotient straight from arithmetic: floor or truncation toward zero.
    function automatic logic [7:0] ref_div(input logic [7:0] av, input int shv);
        int x;
        int q;
        x = int'($signed(av));
`ifdef ITERATIVE_ARITH_SHIFT_DIVIDER_ROUND_TO_ZERO_EN
        q = x / (1 << shv);
`else
        q = x >>> shv;
`endif
        return q[7:0];
    endfunction

    function automatic int eff_shift(input int shv);
        return (shv > N - 1) ? N - 1 : shv;
    endfunction

    // Model scoreboard: expected result plus the cycle at which it must appear.
    typedef struct {
        logic [7:0] exp;
        int         ready_at;
    } pend_t;

    pend_t q[$];
    logic  m_done;
    logic  m_rdy;

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            check("rst_res_vld", 32'(res_vld), 32'(0));
            check("rst_arg_rdy", 32'(arg_rdy), 32'(0));
        end else begin
            m_done = (q.size() > 0) && (cyc >= q[0].ready_at);
            m_rdy  = (q.size() == 0) || (m_done && res_rdy);
            check("res_vld", 32'(res_vld), 32'(m_done));
            check("arg_rdy", 32'(arg_rdy), 32'(m_rdy));
            check("res_known", 32'($isunknown(res)), 32'(0));
            if (m_done) check("res", 32'(res), 32'(q[0].exp));
            if (m_done && res_rdy) void'(q.pop_front());
            if (arg_vld && m_rdy) begin
                q.push_back('{exp: ref_div(a, int'(sh)), ready_at: cyc + eff_shift(int'(sh)) + 1});
                n_acc++;
            end
        end
    end

    task automatic send(input logic [7:0] av, input logic [3:0] shv);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        a       = av;
        sh      = shv;
        arg_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (arg_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("send_accept");
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
    endtask

    task automatic get(input string name, input logic [7:0] exp, input int exp_lat);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (res_vld) begin
                lat  = i;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            fail_now({name, "_timeout"});
        end else begin
            check({name, "_lat"}, 32'(lat), 32'(exp_lat));
            check({name, "_res"}, 32'(res), 32'(exp));
        end
    endtask

    typedef struct {
        logic [7:0] av;
        logic [3:0] shv;
        logic [7:0] ef;
        logic [7:0] et;
        int         lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{av: 8'h9C, shv: 4'd3,  ef: 8'hF3, et: 8'hF4, lat: 4};
        vecs[1] = '{av: 8'd100, shv: 4'd3, ef: 8'd12, et: 8'd12, lat: 4};
        vecs[2] = '{av: 8'h80, shv: 4'd7,  ef: 8'hFF, et: 8'hFF, lat: 8};
        vecs[3] = '{av: 8'h80, shv: 4'd0,  ef: 8'h80, et: 8'h80, lat: 1};
        vecs[4] = '{av: 8'h80, shv: 4'd12, ef: 8'hFF, et: 8'h00, lat: 8};
        vecs[5] = '{av: 8'hFF, shv: 4'd12, ef: 8'hFF, et: 8'h00, lat: 8};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_res", 32'(res), 32'(0));
        check("reset_res_vld", 32'(res_vld), 32'(0));
        check("reset_arg_rdy", 32'(arg_rdy), 32'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_arg_rdy", 32'(arg_rdy), 32'(1));

        // Pin the reference model with hand-computed values
`ifdef ITERATIVE_ARITH_SHIFT_DIVIDER_ROUND_TO_ZERO_EN
        check("model_pin_neg", 32'(ref_div(8'h9C, 3)), 32'(8'hF4));
        check("model_pin_big", 32'(ref_div(8'h80, 12)), 32'(8'h00));
`else
        check("model_pin_neg", 32'(ref_div(8'h9C, 3)), 32'(8'hF3));
        check("model_pin_big", 32'(ref_div(8'h80, 12)), 32'(8'hFF));
`endif

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].av, vecs[i].shv);
`ifdef ITERATIVE_ARITH_SHIFT_DIVIDER_ROUND_TO_ZERO_EN
            get($sformatf("vec%0d", i), vecs[i].et, vecs[i].lat);
`else
            get($sformatf("vec%0d", i), vecs[i].ef, vecs[i].lat);
`endif
        end

        // Backpressure, then same-cycle handoff and accept
        @(posedge clk);
        #1;
        res_rdy = 1'b0;
        send(8'h9C, 4'd3);
`ifdef ITERATIVE_ARITH_SHIFT_DIVIDER_ROUND_TO_ZERO_EN
        get("bp", 8'hF4, 4);
`else
        get("bp", 8'hF3, 4);
`endif
        @(posedge clk);
        #1;
        a       = 8'd64;
        sh      = 4'd1;
        arg_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_vld", 32'(res_vld), 32'(1));
`ifdef ITERATIVE_ARITH_SHIFT_DIVIDER_ROUND_TO_ZERO_EN
            check("bp_hold_res", 32'(res), 32'(8'hF4));
`else
            check("bp_hold_res", 32'(res), 32'(8'hF3));
`endif
            check("bp_hold_rdy", 32'(arg_rdy), 32'(0));
        end
        @(posedge clk);
        #1;
        res_rdy = 1'b1;
        @(negedge clk);
        check("handoff_arg_rdy", 32'(arg_rdy), 32'(1));
        check("handoff_res_vld", 32'(res_vld), 32'(1));
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        get("bp_next", 8'd32, 2);

        // Asynchronous reset in the middle of a shift
        send(8'h9C, 4'd7);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_res_vld", 32'(res_vld), 32'(0));
        check("async_rst_arg_rdy", 32'(arg_rdy), 32'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_arg_rdy", 32'(arg_rdy), 32'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(res_vld), 32'(0));
        end

        // Random traffic checked by the compare process
        begin
            int start;
            int guard;
            start = n_acc;
            guard = 0;
            while ((n_acc - start) < 1000 && guard < 40000) begin
                @(posedge clk);
                #1;
                arg_vld = ($urandom_range(0, 3) != 0);
                a       = 8'($urandom);
                sh      = 4'($urandom_range(0, 15));
                res_rdy = ($urandom_range(0, 3) != 0);
                guard++;
            end
            if (guard >= 40000) fail_now("random_accepts");
        end
        @(posedge clk);
        #1;
        arg_vld = 1'b0;
        res_rdy = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
